// File: rtl/iob_fp_round_pipe.sv
// Two-stage FP rounding/normalization back end: stage 1 applies the rounding
// increment, stage 2 renormalizes and raises the overflow/underflow flags.
module iob_fp_round_pipe #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                sign_i,
    input  logic [2:0]          rmode_i,
    input  logic [EXP_W-1:0]    exponent_i,
    input  logic [DATA_W+2:0]   mantissa_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                sign_o,
    output logic [EXP_W-1:0]    exponent_o,
    output logic [DATA_W-2:0]   mantissa_o,
    output logic                inexact_o,
    output logic                overflow_o,
    output logic                underflow_o
);
    localparam int LZ_W = $clog2(DATA_W + 1);
    localparam int CW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

    logic s2_load, accept;

    // ---------------- stage 1: round ----------------
    logic [DATA_W-1:0] sig;
    logic              lsb, g, r, s, x, inc, spec;

    assign sig  = mantissa_i[DATA_W+2:3];
    assign lsb  = mantissa_i[3];
    assign g    = mantissa_i[2];
    assign r    = mantissa_i[1];
    assign s    = mantissa_i[0];
    assign x    = g | r | s;
    assign spec = &exponent_i;

    always_comb begin
        case (rmode_i)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sign_i & x;
            3'd3:    inc = ~sign_i & x;
            3'd4:    inc = g;
            default: inc = g & (r | s | lsb);
        endcase
    end

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W:0]   s1_sum_q, s1_sum_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_x_q, s1_x_d;
    logic              s1_spec_q, s1_spec_d;

    assign s2_load = cke_i & (~valid_o | ready_i);
    assign ready_o = cke_i & (~s1_vld_q | s2_load);
    assign accept  = valid_i & ready_o;

    // Specials skip the increment so stage 2 sees the raw fraction.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_sum_d  = s1_sum_q;
        s1_exp_d  = s1_exp_q;
        s1_sign_d = s1_sign_q;
        s1_x_d    = s1_x_q;
        s1_spec_d = s1_spec_q;
        if (s2_load) s1_vld_d = 1'b0;
        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_sum_d  = {1'b0, sig} + {{DATA_W{1'b0}}, inc & ~spec};
            s1_exp_d  = exponent_i;
            s1_sign_d = sign_i;
            s1_x_d    = x;
            s1_spec_d = spec;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s1_vld_q  <= 1'b0;
            s1_sum_q  <= '0;
            s1_exp_q  <= '0;
            s1_sign_q <= 1'b0;
            s1_x_q    <= 1'b0;
            s1_spec_q <= 1'b0;
        end else if (cke_i) begin
            s1_vld_q  <= s1_vld_d;
            s1_sum_q  <= s1_sum_d;
            s1_exp_q  <= s1_exp_d;
            s1_sign_q <= s1_sign_d;
            s1_x_q    <= s1_x_d;
            s1_spec_q <= s1_spec_d;
        end
    end

    // ---------------- stage 2: normalize ----------------
    logic [DATA_W-1:0] low, norm;
    logic [LZ_W-1:0]   lzc;
    logic              found;
    logic [EXP_W-1:0]  exp_inc;

    assign low     = s1_sum_q[DATA_W-1:0];
    assign exp_inc = s1_exp_q + EXP_W'(1);
    assign norm    = low << lzc;

    always_comb begin
        lzc   = LZ_W'(DATA_W);
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && low[i]) begin
                lzc   = LZ_W'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
    end

    logic [EXP_W-1:0]  n_exp;
    logic [DATA_W-2:0] n_frac;
    logic              n_inx, n_ovf, n_unf;

    always_comb begin
        n_exp  = s1_exp_q;
        n_frac = s1_sum_q[DATA_W-2:0];
        n_inx  = s1_x_q;
        n_ovf  = 1'b0;
        n_unf  = 1'b0;
        if (s1_spec_q) begin
            n_inx = 1'b0;
        end else if (s1_sum_q[DATA_W]) begin
            // Carry out of the significand: bump exponent; all-ones means infinity.
            n_exp  = exp_inc;
            n_frac = '0;
            n_ovf  = &exp_inc;
        end else if (low == '0) begin
            n_exp  = '0;
            n_frac = '0;
        end else if (CW'(lzc) >= CW'(s1_exp_q)) begin
            n_exp  = '0;
            n_frac = '0;
            n_unf  = 1'b1;
        end else begin
            n_exp  = s1_exp_q - EXP_W'(lzc);
            n_frac = norm[DATA_W-2:0];
        end
    end

    logic              s2_vld_q, s2_vld_d;
    logic              s2_sign_q, s2_sign_d;
    logic [EXP_W-1:0]  s2_exp_q, s2_exp_d;
    logic [DATA_W-2:0] s2_frac_q, s2_frac_d;
    logic              s2_inx_q, s2_inx_d;
    logic              s2_ovf_q, s2_ovf_d;
    logic              s2_unf_q, s2_unf_d;

    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_frac_d = s2_frac_q;
        s2_inx_d  = s2_inx_q;
        s2_ovf_d  = s2_ovf_q;
        s2_unf_d  = s2_unf_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_d = s1_sign_q;
                s2_exp_d  = n_exp;
                s2_frac_d = n_frac;
                s2_inx_d  = n_inx;
                s2_ovf_d  = n_ovf;
                s2_unf_d  = n_unf;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_frac_q <= '0;
            s2_inx_q  <= 1'b0;
            s2_ovf_q  <= 1'b0;
            s2_unf_q  <= 1'b0;
        end else if (cke_i) begin
            s2_vld_q  <= s2_vld_d;
            s2_sign_q <= s2_sign_d;
            s2_exp_q  <= s2_exp_d;
            s2_frac_q <= s2_frac_d;
            s2_inx_q  <= s2_inx_d;
            s2_ovf_q  <= s2_ovf_d;
            s2_unf_q  <= s2_unf_d;
        end
    end

    assign valid_o     = s2_vld_q;
    assign sign_o      = s2_sign_q;
    assign exponent_o  = s2_exp_q;
    assign mantissa_o  = s2_frac_q;
    assign inexact_o   = s2_inx_q;
    assign overflow_o  = s2_ovf_q;
    assign underflow_o = s2_unf_q;

endmodule

// File: doc/iob_fp_round_pipe.md
# iob_fp_round_pipe

Pipelined, multi-mode floating-point rounding and normalization unit with valid/ready handshaking. It takes an unrounded significand with guard/round/sticky bits and one of five IEEE-754 rounding modes, and produces the rounded, renormalized exponent and fraction with status flags. It sits at the back end of the FP add/mul/div datapaths, so that their result stages can be retimed independently of rounding.

## Interface
Parameters:
- DATA_W, 24: significand width including hidden bit.
- EXP_W, 8: exponent width.

Ports:
- clk_i  input  1  clock.
- arst_i  input  1  asynchronous reset, active-high.
- cke_i  input  1  clock enable; low freezes all state.
- valid_i  input  1  input transaction valid.
- ready_o  output  1  unit can accept input this cycle.
- sign_i  input  1  sign of value.
- rmode_i  input  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 treated as RNE.
- exponent_i  input  EXP_W  biased exponent.
- mantissa_i  input  DATA_W+3  [DATA_W+2:3] significand (hidden bit at MSB), [2] guard G, [1] round R, [0] sticky S.
- valid_o  output  1  output valid.
- ready_i  input  1  downstream accepts.
- sign_o  output  1  sign, passed through.
- exponent_o  output  EXP_W  rounded exponent.
- mantissa_o  output  DATA_W-1  rounded fraction (hidden bit dropped).
- inexact_o  output  1  G|R|S was nonzero.
- overflow_o  output  1  rounding carried exponent to all-ones.
- underflow_o  output  1  normalization flushed result to zero.

## Operation
- Stage 1 (round):
  - L = mantissa_i[3]; X = G|R|S.
  - Increment inc: RNE G&(R|S|L); RTZ 0; RDN sign&X; RUP ~sign&X; RMM G.
  - sum = sig + inc, DATA_W+1 bits; register sum, exponent, sign, X, and a special flag (exponent_i all-ones).
- Stage 2 (normalize):
  - Special: exponent and fraction pass through unrounded (sig[DATA_W-2:0]); all flags 0.
  - Carry (sum[DATA_W] set): exponent+1, fraction 0. If the new exponent is all-ones, overflow_o=1 and the result is infinity (exp all-ones, fraction 0).
  - Otherwise lzc = leading zeros of sum[DATA_W-1:0]:
    - sum zero: exponent 0, fraction 0, no underflow.
    - lzc >= exponent with sum nonzero: exponent 0, fraction 0, underflow_o=1.
    - Otherwise: exponent − lzc, fraction = (sum << lzc)[DATA_W-2:0].
  - inexact_o = registered X (0 for specials).
- Handshake:
  - Input accepted when valid_i & ready_o.
  - Output consumed when valid_o & ready_i.
  - Stage 2 loads when empty or consumed. Stage 1 advances when stage 2 loads.
  - ready_o = cke_i & (stage 1 empty | stage 1 advancing).
  - Full throughput with no bubbles. Output data is stable while valid_o & ~ready_i.
- cke_i low: no register updates, ready_o=0, outputs hold.
- Order is strictly preserved. No internal storage beyond the two stages.

## Timing
- Latency: 2 cycles from input acceptance to valid_o, with ready_i high.
- Throughput: 1 per cycle.
- Reset (arst_i asserted, asynchronous): both stage valids and all data registers clear to 0. valid_o=0, all data/flag outputs 0, ready_o=1 from the first cycle after release with cke_i high.
- Reset mid-transaction: in-flight data is discarded, with no partial output.
- Simultaneous accept and consume on a full pipe: both occur and occupancy is unchanged.
- All outputs are registered except ready_o, which is combinational from ready_i, cke_i and the stage valids.

## Test plan
All cases use DATA_W=24, EXP_W=8.
- RNE tie: exp 0x80, sig 0x800001, G=1 R=S=0 -> exp 0x80, fraction 0x000002, inexact 1. Same with sig 0x800000 -> fraction 0x000000, inexact 1.
- Mode sweep: sig 0x800000, G=0 R=1 S=0, sign 1 -> RNE/RTZ/RUP/RMM fraction 0, RDN fraction 1; inexact 1 for all five.
- Carry and overflow: exp 0x10, sig 0xFFFFFF, G=1, RNE -> exp 0x11, fraction 0. Exp 0xFE, same sig -> exp 0xFF, fraction 0, overflow 1. Exp 0xFF input -> passthrough, flags 0.
- Normalize and underflow: exp 0x85, sig 0x0000F0, GRS=0 -> exp 0x75, fraction 0x700000. Exp 0x05, same sig -> exp 0, fraction 0, underflow 1. Sig 0 -> zero, no flags.
- Backpressure: stream 5 back-to-back inputs with ready_i low for cycles 3–6 -> ready_o falls once 2 are held. valid_o and data stay stable. All 5 emerge in order with no loss or duplication; throughput returns to 1/cycle.
- Reset and cke: assert arst_i with both stages full -> valid_o 0 immediately. Hold cke_i low for 2 cycles mid-stream -> no output change, ready_o 0, stream resumes intact.
